// File: rtl/sync_fifo.sv
// sync_fifo: single-clock parametrised FIFO on a RAM array.
// Fill count, almost flags, optional FWFT read, error pulses.
module sync_fifo #(
  parameter int Depth    = 8,
  parameter int Width    = 4,
  parameter int Fwft     = 0,
  parameter int AfThresh = Depth - 2,
  parameter int AeThresh = 1,
  parameter int PtrWidth = $clog2(Depth),
  parameter int CntWidth = $clog2(Depth + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_wr_en,
  input  logic [Width-1:0]    i_wr_data,
  output logic                o_full,
  output logic                o_almost_full,
  input  logic                i_rd_en,
  output logic [Width-1:0]    o_rd_data,
  output logic                o_rd_valid,
  output logic                o_empty,
  output logic                o_almost_empty,
  output logic [CntWidth-1:0] o_count,
  output logic                o_overflow,
  output logic                o_underflow
);

  logic [Width-1:0]    mem [Depth];
  logic [PtrWidth-1:0] wr_ptr;
  logic [PtrWidth-1:0] rd_ptr;
  logic [CntWidth-1:0] count;
  logic [CntWidth-1:0] cnt_nxt;
  logic                wr_acc;
  logic                rd_acc;

  // Flags come from registered state, so a same-cycle
  // read never frees room for a write and vice versa.
  assign wr_acc = i_wr_en & ~o_full;
  assign rd_acc = i_rd_en & ~o_empty;

  // Next fill level; simultaneous push and pop cancel.
  always_comb begin
    cnt_nxt = count;
    case ({wr_acc, rd_acc})
      2'b10:   cnt_nxt = count + 1'b1;
      2'b01:   cnt_nxt = count - 1'b1;
      default: cnt_nxt = count;
    endcase
  end

  // Pointers, count, status flags and error pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      o_full         <= 1'b0;
      o_empty        <= 1'b1;
      o_almost_full  <= 1'b0;
      o_almost_empty <= 1'b1;
      o_overflow     <= 1'b0;
      o_underflow    <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
      count          <= cnt_nxt;
      o_full         <= cnt_nxt == CntWidth'(Depth);
      o_empty        <= cnt_nxt == '0;
      o_almost_full  <= cnt_nxt >= CntWidth'(AfThresh);
      o_almost_empty <= cnt_nxt <= CntWidth'(AeThresh);
      o_overflow     <= i_wr_en & o_full;
      o_underflow    <= i_rd_en & o_empty;
    end
  end

  assign o_count = count;

  // Storage array; contents survive reset on purpose.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr] <= i_wr_data;
  end

  generate
    if (Fwft != 0) begin : g_fwft
      assign o_rd_data  = mem[rd_ptr];
      assign o_rd_valid = ~o_empty;
    end else begin : g_std
      logic [Width-1:0] rd_data_q;
      logic             rd_valid_q;

      // Registered read: word lands one cycle after the pop.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          rd_data_q  <= '0;
          rd_valid_q <= 1'b0;
        end else begin
          rd_valid_q <= rd_acc;
          if (rd_acc) rd_data_q <= mem[rd_ptr];
        end
      end

      assign o_rd_data  = rd_data_q;
      assign o_rd_valid = rd_valid_q;
    end
  endgenerate

endmodule

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo: directed bench with a queue model.
// Checks a standard and a FWFT instance side by side.
module tb_sync_fifo;

  localparam int DEPTH = 8;
  localparam int W     = 4;
  localparam int AF    = DEPTH - 2;
  localparam int AE    = 1;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         wr_en = 1'b0;
  logic [W-1:0] wr_data = '0;
  logic         rd_en = 1'b0;

  logic         full_s, af_s, empty_s, ae_s, vld_s, ovf_s, unf_s;
  logic [W-1:0] data_s;
  logic [3:0]   cnt_s;
  logic         full_f, af_f, empty_f, ae_f, vld_f, ovf_f, unf_f;
  logic [W-1:0] data_f;
  logic [3:0]   cnt_f;

  int nvec = 0;
  int nmis = 0;

  logic [W-1:0] q[$];
  logic [W-1:0] e_ds;
  logic         e_vs, e_ovf, e_unf;

  always #5 clk = ~clk;

  sync_fifo #(.Depth(DEPTH), .Width(W), .Fwft(0)) u_std (
    .clk(clk), .rst(rst),
    .i_wr_en(wr_en), .i_wr_data(wr_data),
    .o_full(full_s), .o_almost_full(af_s),
    .i_rd_en(rd_en), .o_rd_data(data_s),
    .o_rd_valid(vld_s), .o_empty(empty_s),
    .o_almost_empty(ae_s), .o_count(cnt_s),
    .o_overflow(ovf_s), .o_underflow(unf_s)
  );

  sync_fifo #(.Depth(DEPTH), .Width(W), .Fwft(1)) u_fwft (
    .clk(clk), .rst(rst),
    .i_wr_en(wr_en), .i_wr_data(wr_data),
    .o_full(full_f), .o_almost_full(af_f),
    .i_rd_en(rd_en), .o_rd_data(data_f),
    .o_rd_valid(vld_f), .o_empty(empty_f),
    .o_almost_empty(ae_f), .o_count(cnt_f),
    .o_overflow(ovf_f), .o_underflow(unf_f)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    e_ds  = '0;
    e_vs  = 1'b0;
    e_ovf = 1'b0;
    e_unf = 1'b0;
  endtask

  // Behavioural model: one edge of FIFO semantics on a queue.
  task automatic model_edge();
    int n;
    if (rst) begin
      model_reset();
    end else begin
      n     = q.size();
      e_ovf = wr_en && (n == DEPTH);
      e_unf = rd_en && (n == 0);
      e_vs  = 1'b0;
      if (rd_en && n > 0) begin
        e_ds = q.pop_front();
        e_vs = 1'b1;
      end
      if (wr_en && n < DEPTH) q.push_back(wr_data);
    end
  endtask

  task automatic compare_all();
    int n;
    n = q.size();
    chk("cnt_s",   32'(cnt_s),   32'(n));
    chk("cnt_f",   32'(cnt_f),   32'(n));
    chk("empty_s", 32'(empty_s), 32'(n == 0));
    chk("empty_f", 32'(empty_f), 32'(n == 0));
    chk("full_s",  32'(full_s),  32'(n == DEPTH));
    chk("full_f",  32'(full_f),  32'(n == DEPTH));
    chk("af_s",    32'(af_s),    32'(n >= AF));
    chk("af_f",    32'(af_f),    32'(n >= AF));
    chk("ae_s",    32'(ae_s),    32'(n <= AE));
    chk("ae_f",    32'(ae_f),    32'(n <= AE));
    chk("ovf_s",   32'(ovf_s),   32'(e_ovf));
    chk("ovf_f",   32'(ovf_f),   32'(e_ovf));
    chk("unf_s",   32'(unf_s),   32'(e_unf));
    chk("unf_f",   32'(unf_f),   32'(e_unf));
    chk("vld_s",   32'(vld_s),   32'(e_vs));
    chk("data_s",  32'(data_s),  32'(e_ds));
    chk("vld_f",   32'(vld_f),   32'(n > 0));
    if (n > 0) chk("data_f", 32'(data_f), 32'(q[0]));
  endtask

  // Drive from a negedge, step the model at the edge, check at next negedge.
  task automatic cyc(input logic wr, input logic [W-1:0] d,
                     input logic rd);
    wr_en   = wr;
    wr_data = d;
    rd_en   = rd;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    compare_all();
    chk("rst_empty", 32'(empty_s), 32'd1);
    chk("rst_data",  32'(data_s),  32'd0);
    rst = 1'b0;

    // 1: fill to full, then overflow
    for (int i = 1; i <= 8; i++) begin
      cyc(1'b1, W'(i), 1'b0);
      if (i == 5) chk("t1_af5", 32'(af_s), 32'd0);
      if (i == 6) chk("t1_af6", 32'(af_s), 32'd1);
    end
    chk("t1_full", 32'(full_s), 32'd1);
    chk("t1_cnt",  32'(cnt_s),  32'd8);
    cyc(1'b1, 4'hF, 1'b0);
    chk("t1_ovf",  32'(ovf_s),  32'd1);
    cyc(1'b0, 4'h0, 1'b0);
    chk("t1_ovf0", 32'(ovf_s),  32'd0);

    // 2: drain in order, then underflow
    for (int i = 1; i <= 8; i++) begin
      cyc(1'b0, 4'h0, 1'b1);
      chk("t2_data", 32'(data_s), 32'(i));
      chk("t2_vld",  32'(vld_s),  32'd1);
    end
    chk("t2_empty", 32'(empty_s), 32'd1);
    cyc(1'b0, 4'h0, 1'b1);
    chk("t2_unf",  32'(unf_s), 32'd1);
    chk("t2_vld0", 32'(vld_s), 32'd0);
    chk("t2_hold", 32'(data_s), 32'd8);

    // 3: FWFT head appears without a read
    cyc(1'b1, 4'hA, 1'b0);
    chk("t3_vld",  32'(vld_f),  32'd1);
    chk("t3_data", 32'(data_f), 32'hA);
    cyc(1'b0, 4'h0, 1'b0);
    chk("t3_stay", 32'(data_f), 32'hA);
    cyc(1'b0, 4'h0, 1'b1);
    chk("t3_empty", 32'(empty_f), 32'd1);
    chk("t3_vld0",  32'(vld_f),   32'd0);
    chk("t3_std",   32'(data_s),  32'hA);

    // 4: steady count=4 streaming across pointer wraps
    for (int i = 0; i < 4; i++) cyc(1'b1, W'(4'hB + i), 1'b0);
    for (int i = 0; i < 20; i++) begin
      cyc(1'b1, W'(i), 1'b1);
      chk("t4_cnt",  32'(cnt_s), 32'd4);
      chk("t4_data", 32'(data_s),
          (i < 4) ? 32'(4'hB + i) : 32'((i - 4) % 16));
    end

    // 5: full with wr+rd, then empty with wr+rd
    for (int i = 5; i <= 8; i++) cyc(1'b1, W'(i), 1'b0);
    chk("t5_full", 32'(full_s), 32'd1);
    cyc(1'b1, 4'h9, 1'b1);
    chk("t5_ovf",  32'(ovf_s),  32'd1);
    chk("t5_cnt",  32'(cnt_s),  32'd7);
    chk("t5_data", 32'(data_s), 32'h0);
    for (int i = 0; i < 7; i++) cyc(1'b0, 4'h0, 1'b1);
    cyc(1'b1, 4'h7, 1'b1);
    chk("t5_unf",  32'(unf_s), 32'd1);
    chk("t5_cnt1", 32'(cnt_s), 32'd1);
    chk("t5_head", 32'(data_f), 32'h7);
    cyc(1'b0, 4'h0, 1'b1);

    // 6: reset mid-burst discards contents
    for (int i = 0; i < 5; i++) cyc(1'b1, W'(4'hC), 1'b0);
    chk("t6_cnt5", 32'(cnt_s), 32'd5);
    rst = 1'b1;
    #1;
    model_reset();
    compare_all();
    chk("t6_rcnt",  32'(cnt_s),   32'd0);
    chk("t6_rvldf", 32'(vld_f),   32'd0);
    @(negedge clk);
    rst = 1'b0;
    cyc(1'b1, 4'h3, 1'b0);
    chk("t6_headf", 32'(data_f), 32'h3);
    cyc(1'b0, 4'h0, 1'b1);
    chk("t6_data",  32'(data_s), 32'h3);
    chk("t6_empty", 32'(empty_s), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
